// File: rtl/sprite_display_if.sv
// Sprite display bus: pixel position/control in, ROM address out, ROM pixel in,
// composed pixel out. No backpressure: one pixel per clock, always accepted.
// Ports: x, y, video_on, frame_tick, enable, mode, rom_data -> sprite_display;
//        rom_row, rom_col, rgb_out, sprite_on, done <- sprite_display.
// master = video timing / ROM side, slave = sprite_display.
interface sprite_display_if #(
  parameter int COLOR_W = 12
);
  logic [9:0]         x;
  logic [9:0]         y;
  logic               video_on;
  logic               frame_tick;
  logic               enable;
  logic [1:0]         mode;
  logic [5:0]         rom_row;
  logic [8:0]         rom_col;
  logic [COLOR_W-1:0] rom_data;
  logic [COLOR_W-1:0] rgb_out;
  logic               sprite_on;
  logic               done;

  modport master (
    output x, y, video_on, frame_tick, enable, mode, rom_data,
    input  rom_row, rom_col, rgb_out, sprite_on, done
  );

  modport slave (
    input  x, y, video_on, frame_tick, enable, mode, rom_data,
    output rom_row, rom_col, rgb_out, sprite_on, done
  );
endinterface

// File: rtl/sprite_display.sv
// Sprite overlay: registers ROM address from pixel position, aligns hit/visible
// with ROM data and keys out the transparent colour; static, blink and scroll-in.
// Latency x/y -> rgb_out = ROM_LAT+1 clocks. No backpressure (one pixel/clock).
// Ports: clk, reset (async, active high); bus (slave modport) carries the pixel
//   position, frame_tick/enable/mode control, ROM address/data and pixel output.
module sprite_display #(
  parameter int                 X0           = 136,
  parameter int                 Y0           = 64,
  parameter int                 WIDTH        = 368,
  parameter int                 HEIGHT       = 64,
  parameter int                 COLOR_W      = 12,
  parameter int                 ROM_LAT      = 1,
  parameter logic [COLOR_W-1:0] TRANSPARENT  = 12'hF0F,
  parameter int                 BLINK_FRAMES = 30,
  parameter int                 SCROLL_STEP  = 8
) (
  input  logic            clk,
  input  logic            reset,
  sprite_display_if.slave bus
);

  localparam int OFF_W = $clog2(WIDTH + 1);
  localparam int BLK_W = $clog2(BLINK_FRAMES + 1);

  localparam logic [10:0]      X0_X     = 11'(X0);
  localparam logic [10:0]      Y0_X     = 11'(Y0);
  localparam logic [10:0]      XEND_X   = 11'(X0 + WIDTH);
  localparam logic [10:0]      YEND_X   = 11'(Y0 + HEIGHT);
  localparam logic [10:0]      STEP_X   = 11'(SCROLL_STEP);
  localparam logic [OFF_W-1:0] WIDTH_O  = OFF_W'(WIDTH);
  localparam logic [BLK_W-1:0] BLINK_N  = BLK_W'(BLINK_FRAMES);

  typedef enum logic [1:0] {S_OFF, S_SCROLL, S_SHOW, S_BLANK} state_e;

  state_e             state_q, state_d;
  logic [OFF_W-1:0]   offset_q, offset_d;
  logic [BLK_W-1:0]   blink_q, blink_d, blink_inc;
  logic               done_q, done_d;
  logic [5:0]         rom_row_q, rom_row_d;
  logic [8:0]         rom_col_q, rom_col_d;
  logic [ROM_LAT:0]   hit_q, hit_d;
  logic [ROM_LAT:0]   von_q, von_d;
  logic [ROM_LAT:0]   vis_q, vis_d;

  logic [10:0]        x_ext, y_ext, off_ext, x_lim, off_dec;
  logic               hit_now, visible, blink_wrap, sprite_on;

  // Address generation and hit test. The scroll offset shifts the sprite's
  // right edge inward, so the visible window shrinks from the right while
  // the ROM column starts further into the image.
  always_comb begin
    x_ext     = {1'b0, bus.x};
    y_ext     = {1'b0, bus.y};
    off_ext   = 11'(offset_q);
    x_lim     = XEND_X - off_ext;
    hit_now   = bus.video_on &&
                (y_ext >= Y0_X) && (y_ext < YEND_X) &&
                (x_ext >= X0_X) && (x_ext < x_lim);
    rom_row_d = 6'(y_ext - Y0_X);
    rom_col_d = 9'(x_ext - X0_X + off_ext);
    visible   = (state_q == S_SCROLL) || (state_q == S_SHOW);
    // Stage 0 lines up with the registered address; stage ROM_LAT with rom_data.
    hit_d     = {hit_q[ROM_LAT-1:0], hit_now};
    von_d     = {von_q[ROM_LAT-1:0], bus.video_on};
    vis_d     = {vis_q[ROM_LAT-1:0], visible};
  end

  // Frame-level sequencing. Everything moves on frame_tick so offset and
  // visibility are constant across a scanned frame; only enable low acts
  // immediately.
  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    blink_d    = blink_q;
    done_d     = done_q;
    blink_inc  = blink_q + 1'b1;
    blink_wrap = (blink_inc == BLINK_N);
    off_dec    = (off_ext > STEP_X) ? (off_ext - STEP_X) : 11'd0;

    if (!bus.enable) begin
      state_d  = S_OFF;
      offset_d = '0;
      blink_d  = '0;
      done_d   = 1'b0;
    end else begin
      case (state_q)
        S_OFF: begin
          offset_d = '0;
          blink_d  = '0;
          done_d   = 1'b0;
          if (bus.frame_tick) begin
            if (bus.mode == 2'b10) begin
              state_d  = S_SCROLL;
              offset_d = WIDTH_O;
            end else begin
              state_d = S_SHOW;
              done_d  = 1'b1;
            end
          end
        end
        S_SCROLL: begin
          // Mode is ignored here: a started scroll always runs to completion.
          if (bus.frame_tick) begin
            offset_d = OFF_W'(off_dec);
            if (off_dec == 11'd0) begin
              state_d = S_SHOW;
              done_d  = 1'b1;
              blink_d = '0;
            end
          end
        end
        S_SHOW: begin
          if (bus.frame_tick) begin
            if (bus.mode == 2'b01) begin
              if (blink_wrap) begin
                state_d = S_BLANK;
                blink_d = '0;
              end else begin
                blink_d = blink_inc;
              end
            end else begin
              blink_d = '0;
            end
          end
        end
        S_BLANK: begin
          if (bus.frame_tick) begin
            if (bus.mode != 2'b01 || blink_wrap) begin
              state_d = S_SHOW;
              blink_d = '0;
            end else begin
              blink_d = blink_inc;
            end
          end
        end
        default: state_d = S_OFF;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_OFF;
      offset_q  <= '0;
      blink_q   <= '0;
      done_q    <= 1'b0;
      rom_row_q <= '0;
      rom_col_q <= '0;
      hit_q     <= '0;
      von_q     <= '0;
      vis_q     <= '0;
    end else begin
      state_q   <= state_d;
      offset_q  <= offset_d;
      blink_q   <= blink_d;
      done_q    <= done_d;
      rom_row_q <= rom_row_d;
      rom_col_q <= rom_col_d;
      hit_q     <= hit_d;
      von_q     <= von_d;
      vis_q     <= vis_d;
    end
  end

  // Output is combinational from rom_data and the cleared-on-reset delay line,
  // so an asynchronous reset blanks the pixel immediately.
  assign sprite_on     = hit_q[ROM_LAT] && von_q[ROM_LAT] && vis_q[ROM_LAT] &&
                         (bus.rom_data != TRANSPARENT);
  assign bus.sprite_on = sprite_on;
  assign bus.rgb_out   = sprite_on ? bus.rom_data : '0;
  assign bus.done      = done_q;
  assign bus.rom_row   = rom_row_q;
  assign bus.rom_col   = rom_col_q;

endmodule

// File: tb/tb_sprite_display.sv
module tb_sprite_display;
  localparam int X0 = 136, Y0 = 64, W = 368, H = 64, STEP = 8, BF = 30;
  localparam logic [11:0] KEY = 12'hF0F;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sprite_display_if #(.COLOR_W(12)) bus ();

  sprite_display #(
    .X0(X0), .Y0(Y0), .WIDTH(W), .HEIGHT(H), .COLOR_W(12), .ROM_LAT(1),
    .TRANSPARENT(KEY), .BLINK_FRAMES(BF), .SCROLL_STEP(STEP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int rom_sel = 0;

  // Reference model: frame ticks counted since enable, first-tick mode.
  int m_ticks = 0;
  int m_mode0 = 0;
  logic [12:0] expq[$];

  typedef struct {
    int          x;
    int          y;
    bit          von;
    int          rsel;
    logic [11:0] exp_rgb;
    bit          exp_on;
  } vec_t;

  // Sprite image held in the bench: 0 solid green, 1 all key colour, 2 pattern.
  function automatic logic [11:0] rom_val(input int sel, input int r, input int c);
    if (sel == 0) return 12'h0F0;
    if (sel == 1) return KEY;
    if (c % 5 == 0) return KEY;
    return 12'(r * 37 + c * 3 + 1);
  endfunction

  // One-cycle ROM.
  always @(posedge clk)
    bus.rom_data <= rom_val(rom_sel, int'(bus.rom_row), int'(bus.rom_col));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    bus.frame_tick = 1'b1;
    step();
    bus.frame_tick = 1'b0;
  endtask

  task automatic pix(input int x, input int y, input bit v);
    bus.x        = 10'(x);
    bus.y        = 10'(y);
    bus.video_on = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Sprite state from the rules: scroll offset shrinks by STEP each tick after
  // the first, done once it reaches 0; blink alternates every BF frames.
  function automatic void m_view(output bit vis, output int off, output bit dn);
    int kd;
    kd  = (W + STEP - 1) / STEP + 1;
    vis = 1'b0;
    off = 0;
    dn  = 1'b0;
    if (m_ticks == 0) return;
    if (m_mode0 == 2 && m_ticks < kd) begin
      vis = 1'b1;
      off = W - STEP * (m_ticks - 1);
      return;
    end
    dn = 1'b1;
    if (m_mode0 == 1) vis = (((m_ticks - 1) / BF) % 2) == 0;
    else              vis = 1'b1;
  endfunction

  function automatic logic [12:0] m_pixel(input int x, input int y, input bit v,
                                          input bit vis, input int off);
    logic [11:0] val;
    if (!(v && vis && y >= Y0 && y < Y0 + H && x >= X0 && x < X0 + W - off))
      return 13'h0;
    val = rom_val(rom_sel, (y - Y0) % 64, (x - X0 + off) % 512);
    if (val == KEY) return 13'h0;
    return {1'b1, val};
  endfunction

  task automatic rcycle(input bit en, input bit tk, input int x, input int y, input bit v);
    bit          vis, dn;
    int          off;
    logic [12:0] e;
    bus.enable     = en;
    bus.frame_tick = tk;
    pix(x, y, v);
    m_view(vis, off, dn);
    expq.push_back(m_pixel(x, y, v, vis, off));
    if (!en) m_ticks = 0;
    else if (tk) begin
      if (m_ticks == 0) m_mode0 = int'(bus.mode);
      m_ticks++;
    end
    step();
    bus.frame_tick = 1'b0;
    m_view(vis, off, dn);
    chk("rand done", {31'd0, bus.done}, {31'd0, dn});
    if (expq.size() == 2) begin
      e = expq.pop_front();
      chk("rand rgb_out", {20'd0, bus.rgb_out}, {20'd0, e[11:0]});
      chk("rand sprite_on", {31'd0, bus.sprite_on}, {31'd0, e[12]});
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t vecs[12];
    int md, nfr;
    bit en;

    vecs[0]  = '{136,  64, 1'b1, 0, 12'h0F0, 1'b1};
    vecs[1]  = '{135,  64, 1'b1, 0, 12'h000, 1'b0};
    vecs[2]  = '{503,  64, 1'b1, 0, 12'h0F0, 1'b1};
    vecs[3]  = '{504,  64, 1'b1, 0, 12'h000, 1'b0};
    vecs[4]  = '{136,  63, 1'b1, 0, 12'h000, 1'b0};
    vecs[5]  = '{300, 127, 1'b1, 0, 12'h0F0, 1'b1};
    vecs[6]  = '{300, 128, 1'b1, 0, 12'h000, 1'b0};
    vecs[7]  = '{300, 100, 1'b0, 0, 12'h000, 1'b0};
    vecs[8]  = '{300, 100, 1'b1, 1, 12'h000, 1'b0};
    vecs[9]  = '{136,  64, 1'b1, 1, 12'h000, 1'b0};
    vecs[10] = '{300,  90, 1'b1, 2, 12'h5AF, 1'b1};
    vecs[11] = '{141,  64, 1'b1, 2, 12'h000, 1'b0};

    reset = 1'b1;
    bus.enable = 1'b0; bus.mode = 2'b00; bus.frame_tick = 1'b0;
    pix(0, 0, 1'b0);
    step(); step();
    chk("reset rgb_out",   {20'd0, bus.rgb_out}, 32'd0);
    chk("reset sprite_on", {31'd0, bus.sprite_on}, 32'd0);
    chk("reset done",      {31'd0, bus.done}, 32'd0);
    chk("reset rom_row",   {26'd0, bus.rom_row}, 32'd0);
    chk("reset rom_col",   {23'd0, bus.rom_col}, 32'd0);
    reset = 1'b0;

    // Enabled but no frame_tick yet: nothing may be drawn.
    bus.enable = 1'b1;
    pix(200, 100, 1'b1);
    repeat (4) step();
    chk("pre-tick sprite_on", {31'd0, bus.sprite_on}, 32'd0);
    chk("pre-tick done",      {31'd0, bus.done}, 32'd0);
    tick();
    chk("static done", {31'd0, bus.done}, 32'd1);

    // Exact two-clock latency of a single hit pixel.
    pix(135, 64, 1'b1); step(); step();
    pix(136, 64, 1'b1); step();
    chk("latency +1 rgb_out", {20'd0, bus.rgb_out}, 32'd0);
    pix(135, 64, 1'b1); step();
    chk("latency +2 rgb_out",   {20'd0, bus.rgb_out}, 32'h0F0);
    chk("latency +2 sprite_on", {31'd0, bus.sprite_on}, 32'd1);
    step();
    chk("latency +3 rgb_out", {20'd0, bus.rgb_out}, 32'd0);

    for (int i = 0; i < 12; i++) begin
      rom_sel = vecs[i].rsel;
      pix(vecs[i].x, vecs[i].y, vecs[i].von);
      step(); step();
      if (bus.rgb_out !== vecs[i].exp_rgb || bus.sprite_on !== vecs[i].exp_on) begin
        n_fail++;
        $display("FAIL vec[%0d]: got rgb %0h on %0b, expected rgb %0h on %0b",
                 i, bus.rgb_out, bus.sprite_on, vecs[i].exp_rgb, vecs[i].exp_on);
      end
      n_tests++;
    end

    // Scroll-in from the start.
    rom_sel = 0;
    do_reset();
    bus.enable = 1'b1; bus.mode = 2'b10;
    tick();
    pix(136, 64, 1'b1); step();
    chk("scroll t1 rom_col", {23'd0, bus.rom_col}, 32'd368);
    step();
    chk("scroll t1 x136 sprite_on", {31'd0, bus.sprite_on}, 32'd0);
    tick();
    pix(143, 64, 1'b1); step(); step();
    chk("scroll t2 x143 sprite_on", {31'd0, bus.sprite_on}, 32'd1);
    pix(144, 64, 1'b1); step(); step();
    chk("scroll t2 x144 sprite_on", {31'd0, bus.sprite_on}, 32'd0);
    pix(136, 64, 1'b1); step();
    chk("scroll t2 rom_col", {23'd0, bus.rom_col}, 32'd360);
    for (int k = 3; k <= 46; k++) tick();
    chk("scroll done before t47", {31'd0, bus.done}, 32'd0);
    tick();
    chk("scroll done at t47", {31'd0, bus.done}, 32'd1);

    // Enable drop in the middle of a scroll, then restart.
    do_reset();
    bus.enable = 1'b1; bus.mode = 2'b10;
    repeat (10) tick();
    pix(150, 64, 1'b1); step(); step();
    chk("midscroll x150 sprite_on", {31'd0, bus.sprite_on}, 32'd1);
    bus.enable = 1'b0;
    step(); step(); step();
    chk("disable rgb_out", {20'd0, bus.rgb_out}, 32'd0);
    chk("disable done",    {31'd0, bus.done}, 32'd0);
    bus.enable = 1'b1;
    tick();
    pix(136, 64, 1'b1); step();
    chk("restart rom_col", {23'd0, bus.rom_col}, 32'd368);
    step();
    chk("restart x136 sprite_on", {31'd0, bus.sprite_on}, 32'd0);

    // Asynchronous reset between edges while showing.
    do_reset();
    bus.enable = 1'b1; bus.mode = 2'b00;
    tick();
    pix(200, 100, 1'b1); step(); step();
    chk("pre-areset rgb_out", {20'd0, bus.rgb_out}, 32'h0F0);
    #2 reset = 1'b1;
    #1;
    chk("areset rgb_out",   {20'd0, bus.rgb_out}, 32'd0);
    chk("areset sprite_on", {31'd0, bus.sprite_on}, 32'd0);
    chk("areset done",      {31'd0, bus.done}, 32'd0);
    step();
    reset = 1'b0;

    // Randomised episodes against the reference model.
    rom_sel = 2;
    do_reset();
    m_ticks = 0;
    expq.delete();
    for (int ep = 0; ep < 8; ep++) begin
      md  = (ep < 4) ? ep : int'($urandom_range(0, 3));
      nfr = (md == 1) ? 66 : (md == 2) ? 52 : 8;
      bus.mode = 2'(md);
      for (int f = 0; f < nfr; f++) begin
        for (int c = 0; c < 12; c++) begin
          en = !(ep >= 6 && $urandom_range(0, 99) == 0);
          rcycle(en, c == 0, int'($urandom_range(120, 520)),
                 int'($urandom_range(56, 136)), $urandom_range(0, 7) != 0);
        end
      end
      rcycle(1'b0, 1'b0, 200, 100, 1'b1);
      rcycle(1'b0, 1'b0, 200, 100, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
